// File: rtl/fifo_stream_reader_pkg.sv
// Shared definitions for the FIFO stream reader: FSM encoding and skid depth.
package fifo_stream_reader_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_skid_buf2.sv
// Two-entry capture/pop buffer; the word arriving from the FIFO is presented
// directly when the buffer is empty, so a captured word costs no bubble.
module fifo_skid_buf2
    import fifo_stream_reader_pkg::*;
#(
    parameter int data_size = 16
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 push,
    input  logic [data_size-1:0] push_data,
    input  logic                 pop,
    output logic [data_size-1:0] head_data,
    output logic                 head_valid,
    output logic [1:0]           occupancy
);

    logic [data_size-1:0] slot0;
    logic [data_size-1:0] slot1;
    logic [1:0]           occ;

    assign occupancy  = occ;
    assign head_valid = (occ != 2'd0) | push;
    assign head_data  = (occ != 2'd0) ? slot0 : (push ? push_data : '0);

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            slot0 <= '0;
            slot1 <= '0;
            occ   <= 2'd0;
        end else begin
            case (occ)
                2'd0: begin
                    if (push && !pop) begin
                        slot0 <= push_data;
                        occ   <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({push, pop})
                        2'b11: slot0 <= push_data;
                        2'b10: begin
                            slot1 <= push_data;
                            occ   <= 2'(SKID_DEPTH);
                        end
                        2'b01: occ <= 2'd0;
                        default: ;
                    endcase
                end
                default: begin
                    if (pop) begin
                        slot0 <= slot1;
                        if (push) slot1 <= push_data;
                        else      occ   <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains tile_len words per start from a registered-read FIFO and presents
// them as a valid/ready stream with a last marker and a done pulse.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int data_size = 16,
    parameter int cnt_width = 12
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 start,
    input  logic [cnt_width-1:0] tile_len,
    input  logic                 fifo_empty,
    input  logic [data_size-1:0] fifo_dout,
    output logic                 fifo_r_en,
    output logic [data_size-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 busy,
    output logic                 done
);

    state_t               state;
    logic [cnt_width-1:0] len;
    logic [cnt_width-1:0] issue_cnt;
    logic [cnt_width-1:0] out_cnt;
    logic                 inflight;
    logic [1:0]           occupancy;
    logic                 fire;

    fifo_skid_buf2 #(
        .data_size(data_size)
    ) u_skid (
        .clk       (clk),
        .clear     (clear),
        .push      (inflight),
        .push_data (fifo_dout),
        .pop       (fire),
        .head_data (m_data),
        .head_valid(m_valid),
        .occupancy (occupancy)
    );

    assign fire   = m_valid & m_ready;
    assign busy   = (state == RUN);
    assign m_last = m_valid & (out_cnt == len - 1'b1);

    // Words held plus the one in flight must leave room for the next read.
    assign fifo_r_en = (state == RUN) & (issue_cnt < len) & ~fifo_empty &
                       (({1'b0, occupancy} + {2'b00, inflight}) < 3'(SKID_DEPTH));

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state     <= IDLE;
            len       <= '0;
            issue_cnt <= '0;
            out_cnt   <= '0;
            inflight  <= 1'b0;
            done      <= 1'b0;
        end else begin
            inflight <= fifo_r_en;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (tile_len != '0) begin
                            state     <= RUN;
                            len       <= tile_len;
                            issue_cnt <= '0;
                            out_cnt   <= '0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (fifo_r_en) issue_cnt <= issue_cnt + 1'b1;
                    if (fire) begin
                        out_cnt <= out_cnt + 1'b1;
                        if (m_last) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Downstream read controller for the on-chip single-clock activation/weight FIFO.
- Drains exactly tile_len words per start command. It absorbs the FIFO's 1-cycle registered read latency and presents a valid/ready stream with a last marker to the PE-array feeder.
- A 2-entry skid buffer sustains 1 word/cycle with no data loss under back-pressure.

Parameters:
- data_size, 16, word width; matches the FIFO data width.
- cnt_width, 12, width of tile_len and the internal word counters; matches the FIFO log depth.

Ports:
- clk  input  1  rising-edge clock; shared with the FIFO read side.
- clear  input  1  asynchronous active-low reset.
- start  input  1  1-cycle pulse: begin a tile of tile_len words; ignored while busy=1.
- tile_len  input  cnt_width  word count, sampled on an accepted start.
- fifo_empty  input  1  FIFO empty flag, combinational from the FIFO pointers.
- fifo_dout  input  data_size  FIFO registered read data; valid the cycle after an accepted read.
- fifo_r_en  output  1  FIFO read request.
- m_data  output  data_size  stream data.
- m_valid  output  1  stream valid.
- m_ready  input  1  consumer ready.
- m_last  output  1  high with the final word of the tile.
- busy  output  1  tile in progress.
- done  output  1  1-cycle pulse after the tile completes.

Behaviour:
- Reset (clear=0, async): state=IDLE; all counters, skid occupancy and in-flight flag =0. Outputs: fifo_r_en=0, m_valid=0, m_last=0, m_data=0, busy=0, done=0.
- FSM IDLE -> RUN:
  - Transition on start=1 with tile_len!=0.
  - Latch tile_len. Clear issue_cnt and out_cnt. busy=1 from the next cycle.
- start with tile_len=0: stay in IDLE, busy stays 0, done=1 the next cycle, no FIFO reads.
- RUN, read issue:
  - fifo_r_en = (issue_cnt<len) & ~fifo_empty & (occupancy + inflight < 2), where inflight = read issued in the previous cycle.
  - fifo_r_en is combinational from registered state and fifo_empty only; it never depends on m_ready.
  - Each cycle with fifo_r_en=1: issue_cnt+1.
  - The cycle after a read is issued, fifo_dout is written into the skid buffer.
- Skid buffer: 2-entry FIFO order, head drives m_data/m_valid.
  - A word whose capture coincides with a pop of the only entry goes to the head directly; no bubble.
- Output handshake: a word transfers on m_valid & m_ready.
  - out_cnt+1 per transfer.
  - m_last = m_valid & (out_cnt == len-1).
  - m_data and m_last hold stable while m_valid=1 & m_ready=0.
- RUN -> IDLE: on the transfer with m_last=1.
  - Next cycle: busy=0, done=1 for exactly one cycle.
  - A start in that same done cycle is accepted.
- Latency: start -> first fifo_r_en: 1 cycle. fifo_r_en -> m_valid: 1 cycle. With a non-empty FIFO and m_ready=1, start -> first m_valid is 2 cycles.
- Throughput: m_ready held 1 and FIFO never empty gives 1 word/cycle; tile of N words completes in N+2 cycles from start.
- Empty stall: fifo_empty=1 suppresses fifo_r_en; the words already captured still drain; counting resumes when data arrives.
- Max tile: tile_len = 2^cnt_width-1 (4095). Counters never wrap within a tile.
- Arithmetic: all comparisons unsigned, cnt_width bits; occupancy is 2 bits.
- Reset mid-tile: immediate return to IDLE and all state cleared. The FIFO is reset by the same clear, so no stale word is delivered.

Decomposition:
- Shared package: FSM state encoding (IDLE=1'b0, RUN=1'b1) and the SKID_DEPTH=2 constant.
- One sub-module: fifo_skid_buf2 (2-entry capture/pop buffer with occupancy output). The FSM, counters and read issue stay in the top.

Test Plan:
- Basic tile: FIFO preloaded with 0x0001..0x0008, tile_len=8, m_ready=1 -> m_data 0x0001..0x0008 on 8 consecutive cycles starting 2 cycles after start; m_last only on 0x0008; done pulse 1 cycle later; exactly 8 fifo_r_en pulses.
- Back-pressure: tile_len=6, m_ready toggled 1,0,0,1,0,1... -> ordered 6-word sequence with no loss or duplication; m_data stable during stalls; fifo_r_en never issued when occupancy+inflight=2.
- FIFO underflow: FIFO holds 3 words, tile_len=5, two more words written 10 cycles later -> 3 words, gap with m_valid=0 and fifo_r_en=0, then 2 words, m_last on the 5th word.
- Zero/ignored start: start with tile_len=0 -> done next cycle, no fifo_r_en. A start pulse while busy -> ignored, tile length unchanged.
- Reset mid-tile: clear=0 after 3 of 8 words -> all outputs 0 asynchronously. After release with a new start and tile_len=2 -> exactly 2 fresh words delivered.
- Back-to-back tiles: start asserted in the done cycle, tile_len=4 then 4 -> 8 words total, 2 m_last pulses, 2 done pulses.
